usrt_xfer_ctrl: RTL and testbench
=================================

USRT_XFER_CTRL -- requirements
Module: usrt_xfer_ctrl

Interface
REQ-001 The block SHALL have parameter BAUD_EN_RST, default 1'b0, giving the reset value of CTRL.en (USRT clock enable).
REQ-002 The block SHALL have parameter RD_TIMEOUT, default 1023, giving the maximum DATA-read wait in pClk cycles before an error completion.
REQ-003 pClk  in  1  sole clock; all logic on its rising edge.
REQ-004 pReset  in  1  reset, synchronous and active-high.
REQ-005 pSelect  in  1  APB select.
REQ-006 pEnable  in  1  APB access phase.
REQ-007 pWrite  in  1  1 = write, 0 = read.
REQ-008 pAddress  in  4  byte offset: 0x0 DATA, 0x4 STATUS, 0x8 CTRL.
REQ-009 pWData  in  8  write data.
REQ-010 pRData  out  8  read data, valid only while pReady=1, else 0.
REQ-011 pReady  out  1  transfer completion, one-cycle pulse.
REQ-012 pSlvErr  out  1  error response, valid only while pReady=1.
REQ-013 txData  out  8  byte to serializer.
REQ-014 txStart  out  1  one-cycle load strobe to serializer.
REQ-015 txBusy  in  1  serializer shifting a frame.
REQ-016 rxData  in  8  byte from deserializer.
REQ-017 rxValid  in  1  one-cycle strobe, rxData complete and parity-checked.
REQ-018 clkEn  out  1  baud generator enable (= CTRL.en).
REQ-019 uRst  out  1  reset to baud generator, serializer, deserializer.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, TX_WAIT, RX_WAIT, RESP; IDLE->ACCESS on pSelect & !pEnable; ACCESS decodes; RESP drives pReady=1 for one cycle then returns to IDLE.
REQ-021 Write DATA with clkEn=1 and txBusy=0 SHALL register txData=pWData, pulse txStart one cycle and complete in RESP with pSlvErr=0 (pReady 2 cycles after the access phase begins).
REQ-022 Write DATA with txBusy=1 SHALL enter TX_WAIT, hold pReady=0 until txBusy=0, then act per REQ-021.
REQ-023 Write DATA with clkEn=0 SHALL complete with pSlvErr=1 and no txStart.
REQ-024 Read DATA with rx_full=1 SHALL return the held byte, clear rx_full, pSlvErr=0.
REQ-025 Read DATA with rx_full=0 SHALL enter RX_WAIT; completion on rxValid (returning that byte, rx_full unchanged) or after RD_TIMEOUT cycles with pRData=0, pSlvErr=1.
REQ-026 Read STATUS SHALL return {5'b0, overrun, rx_full, txBusy} and clear overrun in the same completion.
REQ-027 Write CTRL SHALL set en=pWData[0]; pWData[1]=1 SHALL assert uRst for exactly 2 cycles and clear rx_full and overrun.
REQ-028 Read CTRL SHALL return {7'b0, en}.
REQ-029 Write STATUS, any unmapped offset, or a DATA write while uRst=1 SHALL complete with pSlvErr=1 and no side effect.
REQ-030 rxValid with rx_full=0 SHALL store rxData and set rx_full; with rx_full=1 SHALL drop the byte and set overrun (sticky).
REQ-031 rxValid in the same cycle as a DATA read of a full buffer SHALL deliver the old byte and store the new one, rx_full stays 1, no overrun.
REQ-032 pSelect deasserted before completion SHALL return the FSM to IDLE without pReady; an already issued txStart is not revoked.
REQ-033 The RX_WAIT timeout counter SHALL be 10 bits minimum, cleared on entry to RX_WAIT, saturating at RD_TIMEOUT.

Reset
REQ-034 While pReset=1: state IDLE, pReady=0, pSlvErr=0, pRData=0, txStart=0, txData=0, rx_full=0, overrun=0, en=BAUD_EN_RST, uRst=1.
REQ-035 uRst SHALL deassert on the first cycle after pReset falls; pReset mid-transfer SHALL abort without pReady.

Structure
REQ-036 Package usrt_pkg SHALL hold the FSM state enum, register offsets (DATA/STATUS/CTRL) and STATUS/CTRL bit positions.
REQ-037 One sub-module rx_hold_buf SHALL implement the one-entry RX buffer with rx_full/overrun (REQ-030/031).

Verification
REQ-038 en=1, txBusy=0, write DATA 0xA5 -> txStart one cycle with txData=0xA5, pReady 2 cycles later, pSlvErr=0.
REQ-039 txBusy=1 for 20 cycles, write DATA 0x3C -> pReady=0 throughout, txStart on first cycle txBusy=0, then completion.
REQ-040 rxValid 0x11 then rxValid 0x22, read STATUS -> 0x06; read again -> 0x02; read DATA -> 0x11, pSlvErr=0.
REQ-041 Read DATA, buffer empty, no rxValid -> pReady after RD_TIMEOUT cycles, pRData=0x00, pSlvErr=1.
REQ-042 Write CTRL 0x03 with rx_full=1 -> uRst high 2 cycles, clkEn=1, STATUS read -> 0x00 (txBusy=0).
REQ-043 Write to offset 0xC and write DATA with en=0 -> pSlvErr=1 each, no txStart.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT APB transfer controller: FSM states,
// register offsets and bit positions of the STATUS and CTRL registers.
package usrt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_TX_WAIT,
        S_RX_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    localparam int ST_TXBUSY  = 0;
    localparam int ST_RXFULL  = 1;
    localparam int ST_OVERRUN = 2;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_URST = 1;

    function automatic logic [7:0] status_byte(input logic ovr, input logic full,
                                               input logic busy);
        logic [7:0] b;
        b             = '0;
        b[ST_OVERRUN] = ovr;
        b[ST_RXFULL]  = full;
        b[ST_TXBUSY]  = busy;
        return b;
    endfunction

endpackage

// File: rtl/rx_hold_buf.sv
// One-entry receive holding buffer with sticky overrun flag. A byte taken
// straight off the deserializer by a waiting read never lands in the buffer.
module rx_hold_buf
    import usrt_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    input  logic       i_pop,
    input  logic       i_take,
    input  logic       i_ovr_clr,
    input  logic       i_clr,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_overrun
);

    logic [7:0] r_data;
    logic       r_full;
    logic       r_overrun;
    logic       w_offer;
    logic       w_store;
    logic       w_drop;

    // A pop in the same cycle frees the slot, so the new byte replaces the old one.
    assign w_offer = i_rx_valid && !i_take;
    assign w_store = w_offer && (!r_full || i_pop);
    assign w_drop  = w_offer && r_full && !i_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else if (i_clr) begin
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_store)
                r_full <= 1'b1;
            else if (i_pop)
                r_full <= 1'b0;
            // A fresh overrun wins over the clear from a STATUS read snapshot.
            if (w_drop)
                r_overrun <= 1'b1;
            else if (i_ovr_clr)
                r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_store)
            r_data <= i_rx_data;
    end

    assign o_data    = r_data;
    assign o_full    = r_full;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/usrt_xfer_ctrl.sv
// APB slave front end of the USRT: decodes DATA/STATUS/CTRL accesses, hands
// bytes to the serializer, collects bytes from the deserializer.
module usrt_xfer_ctrl
    import usrt_pkg::*;
#(
    parameter logic BAUD_EN_RST = 1'b0,
    parameter int   RD_TIMEOUT  = 1023
) (
    input  logic       pClk,
    input  logic       pReset,
    input  logic       pSelect,
    input  logic       pEnable,
    input  logic       pWrite,
    input  logic [3:0] pAddress,
    input  logic [7:0] pWData,
    output logic [7:0] pRData,
    output logic       pReady,
    output logic       pSlvErr,
    output logic [7:0] txData,
    output logic       txStart,
    input  logic       txBusy,
    input  logic [7:0] rxData,
    input  logic       rxValid,
    output logic       clkEn,
    output logic       uRst
);

    localparam int CNT_W = ($clog2(RD_TIMEOUT + 1) > 10) ? $clog2(RD_TIMEOUT + 1) : 10;
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(RD_TIMEOUT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_pRData;
    logic             r_pReady;
    logic             r_pSlvErr;
    logic [7:0]       r_txData;
    logic             r_txStart;
    logic             r_en;
    logic             r_uRst;
    logic             r_urst_left;
    logic [7:0]       r_resp_data;
    logic             r_resp_err;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic             w_tx_load;
    logic             w_resp_set;
    logic [7:0]       w_resp_data;
    logic             w_resp_err;
    logic             w_pop;
    logic             w_take;
    logic             w_ovr_clr;
    logic             w_urst_set;
    logic             w_en_wr;
    logic             w_ready_set;
    logic             w_cnt_clr;
    logic [7:0]       w_rx_byte;
    logic             w_rx_full;
    logic             w_rx_ovr;

    rx_hold_buf u_rx_hold_buf (
        .i_clk      (pClk),
        .i_rst      (pReset),
        .i_rx_valid (rxValid),
        .i_rx_data  (rxData),
        .i_pop      (w_pop),
        .i_take     (w_take),
        .i_ovr_clr  (w_ovr_clr),
        .i_clr      (w_urst_set),
        .o_data     (w_rx_byte),
        .o_full     (w_rx_full),
        .o_overrun  (w_rx_ovr)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_tx_load   = 1'b0;
        w_resp_set  = 1'b0;
        w_resp_data = '0;
        w_resp_err  = 1'b0;
        w_pop       = 1'b0;
        w_take      = 1'b0;
        w_ovr_clr   = 1'b0;
        w_urst_set  = 1'b0;
        w_en_wr     = 1'b0;
        w_ready_set = 1'b0;
        w_cnt_clr   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (pSelect && !pEnable)
                    w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (!pSelect) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_resp_set = 1'b1;
                    case (pAddress)
                        ADDR_DATA: begin
                            if (pWrite) begin
                                if (r_uRst || !r_en) begin
                                    w_resp_err = 1'b1;
                                end else if (txBusy) begin
                                    w_resp_set  = 1'b0;
                                    w_state_nxt = S_TX_WAIT;
                                end else begin
                                    w_tx_load = 1'b1;
                                end
                            end else if (w_rx_full) begin
                                w_pop       = 1'b1;
                                w_resp_data = w_rx_byte;
                            end else if (rxValid) begin
                                w_take      = 1'b1;
                                w_resp_data = rxData;
                            end else begin
                                w_resp_set  = 1'b0;
                                w_cnt_clr   = 1'b1;
                                w_state_nxt = S_RX_WAIT;
                            end
                        end
                        ADDR_STATUS: begin
                            if (pWrite) begin
                                w_resp_err = 1'b1;
                            end else begin
                                w_resp_data = status_byte(w_rx_ovr, w_rx_full, txBusy);
                                w_ovr_clr   = 1'b1;
                            end
                        end
                        ADDR_CTRL: begin
                            if (pWrite) begin
                                w_en_wr    = 1'b1;
                                w_urst_set = pWData[CTRL_URST];
                            end else begin
                                w_resp_data[CTRL_EN] = r_en;
                            end
                        end
                        default: w_resp_err = 1'b1;
                    endcase
                    if (w_resp_set)
                        w_state_nxt = S_RESP;
                end
            end
            S_TX_WAIT: begin
                if (!pSelect) begin
                    w_state_nxt = S_IDLE;
                end else if (!txBusy) begin
                    w_tx_load   = 1'b1;
                    w_resp_set  = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RX_WAIT: begin
                if (!pSelect) begin
                    w_state_nxt = S_IDLE;
                end else if (rxValid) begin
                    w_take      = 1'b1;
                    w_resp_data = rxData;
                    w_resp_set  = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (r_tmo_cnt == TMO_VAL) begin
                    w_resp_err  = 1'b1;
                    w_resp_set  = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // A master that dropped pSelect here has abandoned the transfer.
                w_ready_set = pSelect;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            r_state     <= S_IDLE;
            r_pReady    <= 1'b0;
            r_pSlvErr   <= 1'b0;
            r_pRData    <= '0;
            r_txStart   <= 1'b0;
            r_txData    <= '0;
            r_en        <= BAUD_EN_RST;
            r_uRst      <= 1'b1;
            r_urst_left <= 1'b0;
            r_resp_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pReady  <= w_ready_set;
            r_pSlvErr <= w_ready_set && r_resp_err;
            r_pRData  <= w_ready_set ? r_resp_data : 8'h00;
            r_txStart <= w_tx_load;
            if (w_tx_load)
                r_txData <= pWData;
            if (w_resp_set)
                r_resp_err <= w_resp_err;
            if (w_en_wr)
                r_en <= pWData[CTRL_EN];
            // Two-cycle peripheral reset: set cycle plus one extension cycle.
            if (w_urst_set) begin
                r_uRst      <= 1'b1;
                r_urst_left <= 1'b1;
            end else begin
                r_uRst      <= r_urst_left;
                r_urst_left <= 1'b0;
            end
        end
    end

    always_ff @(posedge pClk) begin
        if (w_resp_set)
            r_resp_data <= w_resp_data;
        if (w_cnt_clr)
            r_tmo_cnt <= '0;
        else if (r_state == S_RX_WAIT && r_tmo_cnt != TMO_VAL)
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end

    assign pRData  = r_pRData;
    assign pReady  = r_pReady;
    assign pSlvErr = r_pSlvErr;
    assign txData  = r_txData;
    assign txStart = r_txStart;
    assign clkEn   = r_en;
    assign uRst    = r_uRst;

endmodule

// File: tb/tb_usrt_xfer_ctrl.sv
// Bench for usrt_xfer_ctrl: register access vectors from a table, then
// hand-written sequences for waits, RX buffering, timeout, resets and aborts.
module tb_usrt_xfer_ctrl;

    localparam int RD_TMO = 1023;

    logic       pClk;
    logic       pReset;
    logic       pSelect;
    logic       pEnable;
    logic       pWrite;
    logic [3:0] pAddress;
    logic [7:0] pWData;
    logic [7:0] pRData;
    logic       pReady;
    logic       pSlvErr;
    logic [7:0] txData;
    logic       txStart;
    logic       txBusy;
    logic [7:0] rxData;
    logic       rxValid;
    logic       clkEn;
    logic       uRst;

    usrt_xfer_ctrl #(.BAUD_EN_RST(1'b0), .RD_TIMEOUT(RD_TMO)) dut (
        .pClk     (pClk),
        .pReset   (pReset),
        .pSelect  (pSelect),
        .pEnable  (pEnable),
        .pWrite   (pWrite),
        .pAddress (pAddress),
        .pWData   (pWData),
        .pRData   (pRData),
        .pReady   (pReady),
        .pSlvErr  (pSlvErr),
        .txData   (txData),
        .txStart  (txStart),
        .txBusy   (txBusy),
        .rxData   (rxData),
        .rxValid  (rxValid),
        .clkEn    (clkEn),
        .uRst     (uRst)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    int checks = 0;
    int errors = 0;
    int ts_total = 0;
    int urst_hi = 0;

    always @(negedge pClk) begin
        if (txStart) ts_total++;
        if (uRst && !pReset) urst_hi++;
    end

    typedef struct {
        bit         wr;
        logic [3:0] addr;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        bit         exp_err;
        bit         exp_ts;
        logic [7:0] exp_txd;
    } vec_t;

    vec_t vt[12];

    logic [7:0] rd, td;
    logic       er;
    int         ri, ti, ts0;
    bit         seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One APB transfer; indices count cycles from the first access-phase cycle.
    task automatic apb_xfer(input bit wr, input logic [3:0] addr, input logic [7:0] wd,
                            input int busy, input int rx_idx, input logic [7:0] rx_byte,
                            input int max_cyc, output logic [7:0] o_rd, output logic o_err,
                            output int o_rdy, output int o_ts, output logic [7:0] o_tsd);
        int k;
        o_rdy = -1; o_ts = -1; o_rd = 8'h00; o_err = 1'b0; o_tsd = 8'h00;
        @(posedge pClk); #1;
        pSelect = 1'b1; pEnable = 1'b0; pWrite = wr; pAddress = addr; pWData = wd;
        if (busy > 0) txBusy = 1'b1;
        @(posedge pClk); #1;
        pEnable = 1'b1;
        k = 0;
        if (rx_idx == 0) begin rxValid = 1'b1; rxData = rx_byte; end
        forever begin
            @(negedge pClk);
            if (txStart && o_ts < 0) begin o_ts = k; o_tsd = txData; end
            if (pReady) begin o_rdy = k; o_rd = pRData; o_err = pSlvErr; break; end
            if (k >= max_cyc) break;
            @(posedge pClk); #1;
            k++;
            if (k == busy) txBusy = 1'b0;
            if (k == rx_idx) begin rxValid = 1'b1; rxData = rx_byte; end
            else if (k == rx_idx + 1) rxValid = 1'b0;
        end
        @(posedge pClk); #1;
        pSelect = 1'b0; pEnable = 1'b0; rxValid = 1'b0; txBusy = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(posedge pClk); #1;
        rxValid = 1'b1; rxData = b;
        @(posedge pClk); #1;
        rxValid = 1'b0;
    endtask

    task automatic simple(input string nm, input bit wr, input logic [3:0] addr,
                          input logic [7:0] wd, input logic [7:0] exp_rd, input bit exp_err);
        apb_xfer(wr, addr, wd, 0, -1, 8'h00, 20, rd, er, ri, ti, td);
        chk({nm, "_ready_idx"}, ri, 2);
        chk({nm, "_rdata"}, rd, exp_rd);
        chk({nm, "_slverr"}, er, exp_err);
    endtask

    initial begin
        pReset = 1'b1; pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
        pAddress = 4'h0; pWData = 8'h00; txBusy = 1'b0; rxData = 8'h00; rxValid = 1'b0;

        vt[0]  = '{0, 4'h8, 8'h00, 8'h00, 0, 0, 8'h00};
        vt[1]  = '{1, 4'h0, 8'h55, 8'h00, 1, 0, 8'h00};
        vt[2]  = '{1, 4'hC, 8'h00, 8'h00, 1, 0, 8'h00};
        vt[3]  = '{0, 4'hC, 8'h00, 8'h00, 1, 0, 8'h00};
        vt[4]  = '{1, 4'h4, 8'hFF, 8'h00, 1, 0, 8'h00};
        vt[5]  = '{0, 4'h4, 8'h00, 8'h00, 0, 0, 8'h00};
        vt[6]  = '{1, 4'h8, 8'h01, 8'h00, 0, 0, 8'h00};
        vt[7]  = '{0, 4'h8, 8'h00, 8'h01, 0, 0, 8'h00};
        vt[8]  = '{1, 4'h0, 8'hA5, 8'h00, 0, 1, 8'hA5};
        vt[9]  = '{1, 4'h8, 8'h00, 8'h00, 0, 0, 8'h00};
        vt[10] = '{0, 4'h8, 8'h00, 8'h00, 0, 0, 8'h00};
        vt[11] = '{1, 4'h8, 8'h01, 8'h00, 0, 0, 8'h00};

        repeat (3) @(posedge pClk);
        @(negedge pClk);
        chk("rst_pready", pReady, 0);
        chk("rst_pslverr", pSlvErr, 0);
        chk("rst_prdata", pRData, 0);
        chk("rst_txstart", txStart, 0);
        chk("rst_txdata", txData, 0);
        chk("rst_clken", clkEn, 0);
        chk("rst_urst", uRst, 1);
        @(posedge pClk); #1;
        pReset = 1'b0;
        repeat (2) @(negedge pClk);
        chk("urst_release", uRst, 0);

        for (int i = 0; i < 12; i++) begin
            ts0 = ts_total;
            apb_xfer(vt[i].wr, vt[i].addr, vt[i].wd, 0, -1, 8'h00, 20, rd, er, ri, ti, td);
            chk($sformatf("vec%0d_ready_idx", i), ri, 2);
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_slverr", i), er, vt[i].exp_err);
            chk($sformatf("vec%0d_txstart_cnt", i), ts_total - ts0, vt[i].exp_ts ? 1 : 0);
            if (vt[i].exp_ts) begin
                chk($sformatf("vec%0d_txstart_idx", i), ti, 1);
                chk($sformatf("vec%0d_txdata", i), td, vt[i].exp_txd);
            end
        end

        // Serializer busy for 20 cycles of the access.
        ts0 = ts_total;
        apb_xfer(1, 4'h0, 8'h3C, 20, -1, 8'h00, 60, rd, er, ri, ti, td);
        chk("txwait_txstart_idx", ti, 21);
        chk("txwait_ready_idx", ri, 22);
        chk("txwait_txdata", td, 8'h3C);
        chk("txwait_slverr", er, 0);
        chk("txwait_txstart_cnt", ts_total - ts0, 1);

        // Overrun then STATUS/DATA reads.
        rx_push(8'h11);
        rx_push(8'h22);
        simple("ovr_status1", 0, 4'h4, 8'h00, 8'h06, 0);
        simple("ovr_status2", 0, 4'h4, 8'h00, 8'h02, 0);
        simple("ovr_data", 0, 4'h0, 8'h00, 8'h11, 0);
        simple("ovr_status3", 0, 4'h4, 8'h00, 8'h00, 0);

        // New byte arriving while the full buffer is being read.
        rx_push(8'h33);
        apb_xfer(0, 4'h0, 8'h00, 0, 0, 8'h44, 20, rd, er, ri, ti, td);
        chk("swap_ready_idx", ri, 2);
        chk("swap_rdata", rd, 8'h33);
        chk("swap_slverr", er, 0);
        simple("swap_status", 0, 4'h4, 8'h00, 8'h02, 0);
        simple("swap_data2", 0, 4'h0, 8'h00, 8'h44, 0);
        simple("swap_status2", 0, 4'h4, 8'h00, 8'h00, 0);

        // Read waits on an empty buffer, byte arrives mid-wait.
        apb_xfer(0, 4'h0, 8'h00, 0, 5, 8'h5A, 40, rd, er, ri, ti, td);
        chk("rxwait_ready_idx", ri, 7);
        chk("rxwait_rdata", rd, 8'h5A);
        chk("rxwait_slverr", er, 0);
        simple("rxwait_status", 0, 4'h4, 8'h00, 8'h00, 0);

        // Read times out on an empty buffer.
        apb_xfer(0, 4'h0, 8'h00, 0, -1, 8'h00, RD_TMO + 100, rd, er, ri, ti, td);
        chk("tmo_ready_window", (ri >= RD_TMO && ri <= RD_TMO + 3) ? 1 : 0, 1);
        chk("tmo_rdata", rd, 8'h00);
        chk("tmo_slverr", er, 1);

        // CTRL write with peripheral reset while the buffer is full.
        rx_push(8'h77);
        urst_hi = 0;
        simple("ctrl_urst", 1, 4'h8, 8'h03, 8'h00, 0);
        repeat (3) @(negedge pClk);
        chk("ctrl_urst_cycles", urst_hi, 2);
        chk("ctrl_clken", clkEn, 1);
        simple("ctrl_status", 0, 4'h4, 8'h00, 8'h00, 0);

        // Master abandons a DATA write stuck behind a busy serializer.
        ts0 = ts_total;
        seen = 1'b0;
        @(posedge pClk); #1;
        txBusy = 1'b1; pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b1;
        pAddress = 4'h0; pWData = 8'h99;
        @(posedge pClk); #1;
        pEnable = 1'b1;
        repeat (3) @(posedge pClk);
        #1;
        pSelect = 1'b0; pEnable = 1'b0;
        repeat (3) begin @(negedge pClk); if (pReady) seen = 1'b1; end
        txBusy = 1'b0;
        repeat (4) begin @(negedge pClk); if (pReady) seen = 1'b1; end
        chk("abort_no_ready", seen, 0);
        chk("abort_no_txstart", ts_total - ts0, 0);
        simple("abort_after", 0, 4'h4, 8'h00, 8'h00, 0);

        // Reset in the middle of a waiting read.
        seen = 1'b0;
        @(posedge pClk); #1;
        pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddress = 4'h0;
        @(posedge pClk); #1;
        pEnable = 1'b1;
        repeat (5) begin @(negedge pClk); if (pReady) seen = 1'b1; end
        @(posedge pClk); #1;
        pReset = 1'b1;
        repeat (3) begin @(negedge pClk); if (pReady) seen = 1'b1; end
        chk("midrst_urst", uRst, 1);
        chk("midrst_clken", clkEn, 0);
        @(posedge pClk); #1;
        pReset = 1'b0; pSelect = 1'b0; pEnable = 1'b0;
        repeat (4) begin @(negedge pClk); if (pReady) seen = 1'b1; end
        chk("midrst_no_ready", seen, 0);
        simple("midrst_ctrl", 0, 4'h8, 8'h00, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
